// File: rtl/axi_lite_if.sv
// AXI-Lite style register bus: decoupled write address/data, write response and read channels.
interface axi_lite_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] waddr;
  logic                  wavalid;
  logic                  waready;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bdata;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] raddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output waddr, wavalid, wdata, wvalid, bready, raddr, arvalid, rready,
    input  waready, wready, bdata, bvalid, arready, rdata, rvalid
  );

  modport slave (
    input  waddr, wavalid, wdata, wvalid, bready, raddr, arvalid, rready,
    output waready, wready, bdata, bvalid, arready, rdata, rvalid
  );
endinterface

// File: rtl/axi_lite_reg_slave.sv
// Register-bank responder: NUM_REGS word registers with flat contents and per-register write pulses.
// Write address and data land in independent one-entry slots and commit once both are full.
module axi_lite_reg_slave #(
  parameter int                    ADDR_WIDTH = 5,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 6,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  axi_lite_if.slave                      s_axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);
  localparam int                IDX_W      = ADDR_WIDTH - 2;
  localparam logic [IDX_W:0]    NUM_REGS_W = (IDX_W+1)'(NUM_REGS);

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_SLVERR = 2'd2
  } resp_t;

  logic                  aw_held_reg, aw_held_next;
  logic                  w_held_reg, w_held_next;
  logic [IDX_W-1:0]      aw_idx_reg;
  logic [DATA_WIDTH-1:0] w_data_reg;
  logic                  waready_reg;
  logic                  wready_reg;
  logic                  bvalid_reg, bvalid_next;
  resp_t                 bresp_reg, bresp_next;
  logic                  rvalid_reg, rvalid_next;
  logic [DATA_WIDTH-1:0] rdata_reg, rdata_next;
  logic [NUM_REGS-1:0]   wr_pulse_reg;
  logic [NUM_REGS-1:0]   reg_we;
  logic [DATA_WIDTH-1:0] rd_val;
  logic [IDX_W-1:0]      ar_idx;
  logic                  aw_hs, w_hs, ar_hs, commit, aw_in_range, arready_int;

  // Byte-offset bits are ignored: unaligned addresses alias to their word.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi.waddr[1:0], s_axi.raddr[1:0]};

  assign ar_idx      = s_axi.raddr[ADDR_WIDTH-1:2];
  assign aw_hs       = s_axi.wavalid && waready_reg;
  assign w_hs        = s_axi.wvalid && wready_reg;
  assign commit      = aw_held_reg && w_held_reg && (!bvalid_reg || s_axi.bready);
  assign aw_in_range = {1'b0, aw_idx_reg} < NUM_REGS_W;
  assign arready_int = rst_n && (!rvalid_reg || s_axi.rready);
  assign ar_hs       = s_axi.arvalid && arready_int;

  assign s_axi.waready = waready_reg;
  assign s_axi.wready  = wready_reg;
  assign s_axi.bvalid  = bvalid_reg;
  assign s_axi.bdata   = bresp_reg;
  assign s_axi.arready = arready_int;
  assign s_axi.rvalid  = rvalid_reg;
  assign s_axi.rdata   = rdata_reg;
  assign wr_pulse_o    = wr_pulse_reg;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    logic [DATA_WIDTH-1:0] value_reg;

    // Out-of-range indices never match any gi, so they write nothing.
    assign reg_we[gi] = commit && (aw_idx_reg == IDX_W'(gi));
    assign regs_o[gi*DATA_WIDTH +: DATA_WIDTH] = value_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        value_reg <= RESET_VAL;
      end else if (reg_we[gi]) begin
        value_reg <= w_data_reg;
      end
    end
  end

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == IDX_W'(i)) rd_val = regs_o[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    aw_held_next = aw_held_reg;
    w_held_next  = w_held_reg;
    bvalid_next  = bvalid_reg;
    bresp_next   = bresp_reg;
    rvalid_next  = rvalid_reg;
    rdata_next   = rdata_reg;
    if (s_axi.bready) bvalid_next = 1'b0;
    // A commit in the same cycle as a bready handshake replaces the response.
    if (commit) begin
      aw_held_next = 1'b0;
      w_held_next  = 1'b0;
      bvalid_next  = 1'b1;
      bresp_next   = aw_in_range ? RESP_OKAY : RESP_SLVERR;
    end
    if (aw_hs) aw_held_next = 1'b1;
    if (w_hs)  w_held_next  = 1'b1;
    if (s_axi.rready) rvalid_next = 1'b0;
    if (ar_hs) begin
      rvalid_next = 1'b1;
      rdata_next  = rd_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held_reg  <= 1'b0;
      w_held_reg   <= 1'b0;
      aw_idx_reg   <= '0;
      w_data_reg   <= '0;
      waready_reg  <= 1'b0;
      wready_reg   <= 1'b0;
      bvalid_reg   <= 1'b0;
      bresp_reg    <= RESP_OKAY;
      rvalid_reg   <= 1'b0;
      rdata_reg    <= '0;
      wr_pulse_reg <= '0;
    end else begin
      aw_held_reg  <= aw_held_next;
      w_held_reg   <= w_held_next;
      waready_reg  <= !aw_held_next;
      wready_reg   <= !w_held_next;
      bvalid_reg   <= bvalid_next;
      bresp_reg    <= bresp_next;
      rvalid_reg   <= rvalid_next;
      rdata_reg    <= rdata_next;
      wr_pulse_reg <= reg_we;
      if (aw_hs) aw_idx_reg <= s_axi.waddr[ADDR_WIDTH-1:2];
      if (w_hs)  w_data_reg <= s_axi.wdata;
    end
  end
endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed plus randomized bench for axi_lite_reg_slave against an array-based register model.
module tb_axi_lite_reg_slave;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR*DW-1:0]  regs_o;
  logic [NR-1:0]     wr_pulse_o;
  int                vectors = 0;
  int                miscompares = 0;
  logic [DW-1:0]     model [NR];

  axi_lite_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi_lite_reg_slave #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .RESET_VAL('0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_axi      (bus.slave),
    .regs_o     (regs_o),
    .wr_pulse_o (wr_pulse_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int idx_of(input logic [AW-1:0] a);
    return int'(a) / 4;
  endfunction

  function automatic logic [NR*DW-1:0] model_flat();
    logic [NR*DW-1:0] f;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = model[i];
    return f;
  endfunction

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    return (idx_of(a) < NR) ? model[idx_of(a)] : '0;
  endfunction

  function automatic logic [1:0] exp_resp(input logic [AW-1:0] a);
    return (idx_of(a) < NR) ? 2'd0 : 2'd2;
  endfunction

  function automatic logic [NR-1:0] exp_pulse(input logic [AW-1:0] a);
    logic [NR-1:0] p;
    p = '0;
    if (idx_of(a) < NR) p[idx_of(a)] = 1'b1;
    return p;
  endfunction

  task automatic send_aw(input logic [AW-1:0] a, input int lead);
    int n = 0;
    repeat (lead) @(negedge clk);
    @(negedge clk);
    bus.waddr = a;
    bus.wavalid = 1'b1;
    while (!bus.waready && n < 40) begin @(negedge clk); n++; end
    chk("aw_handshake", bus.waready, 1);
    @(posedge clk);
    #1 bus.wavalid = 1'b0;
  endtask

  task automatic send_w(input logic [DW-1:0] d, input int lead);
    int n = 0;
    repeat (lead) @(negedge clk);
    @(negedge clk);
    bus.wdata = d;
    bus.wvalid = 1'b1;
    while (!bus.wready && n < 40) begin @(negedge clk); n++; end
    chk("w_handshake", bus.wready, 1);
    @(posedge clk);
    #1 bus.wvalid = 1'b0;
  endtask

  // Called just after the later of the two handshakes, with bready = 1.
  task automatic wait_b(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    do begin @(negedge clk); n++; end while (!bus.bvalid && n < 20);
    chk($sformatf("b_latency@%0h", a), n, 2);
    chk($sformatf("bdata@%0h", a), bus.bdata, exp_resp(a));
    if (idx_of(a) < NR) model[idx_of(a)] = d;
    chk($sformatf("wr_pulse@%0h", a), wr_pulse_o, exp_pulse(a));
    chk($sformatf("regs@%0h", a), regs_o, model_flat());
    @(negedge clk);
    chk("bvalid_clear", bus.bvalid, 0);
    chk("pulse_clear", wr_pulse_o, 0);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int la, input int lw);
    fork
      send_aw(a, la);
      send_w(d, lw);
    join
    wait_b(a, d);
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    @(negedge clk);
    bus.rready = 1'b1;
    bus.raddr = a;
    bus.arvalid = 1'b1;
    chk("arready", bus.arready, 1);
    @(posedge clk);
    #1 bus.arvalid = 1'b0;
    @(negedge clk);
    chk($sformatf("rvalid@%0h", a), bus.rvalid, 1);
    chk($sformatf("rdata@%0h", a), bus.rdata, model_read(a));
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int n;

    for (int i = 0; i < NR; i++) model[i] = '0;
    bus.waddr = '0; bus.wavalid = 1'b0; bus.wdata = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b1; bus.raddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;

    // Reset state
    #12;
    chk("rst_waready", bus.waready, 0);
    chk("rst_wready", bus.wready, 0);
    chk("rst_bvalid", bus.bvalid, 0);
    chk("rst_bdata", bus.bdata, 0);
    chk("rst_arready", bus.arready, 0);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_regs", regs_o, 0);
    chk("rst_pulse", wr_pulse_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_waready", bus.waready, 1);
    chk("post_rst_wready", bus.wready, 1);

    // 1: aligned write, both halves together
    do_write(5'h08, 32'hA5A5_0001, 0, 0);

    // 2: data leads address by several cycles
    send_w(32'h0000_1234, 0);
    @(negedge clk);
    chk("t2_wready_low", bus.wready, 0);
    chk("t2_waready_high", bus.waready, 1);
    chk("t2_no_commit", bus.bvalid, 0);
    send_aw(5'h04, 2);
    wait_b(5'h04, 32'h0000_1234);

    // 3: out-of-range write and read
    do_write(5'h18, 32'hFFFF_FFFF, 0, 0);
    do_read(5'h1C);

    // 4: response backpressure with a second write queued in the slots
    bus.bready = 1'b0;
    fork
      send_aw(5'h1A, 0);
      send_w(32'hDEAD_BEEF, 0);
    join
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.bvalid && n < 20);
    chk("t4_b1_valid", bus.bvalid, 1);
    chk("t4_b1_bdata", bus.bdata, 2);
    repeat (5) begin
      @(negedge clk);
      chk("t4_b1_hold", {bus.bvalid, bus.bdata}, {1'b1, 2'd2});
    end
    fork
      send_aw(5'h0C, 0);
      send_w(32'hC0DE_0003, 0);
    join
    @(negedge clk);
    chk("t4_slots_full", {bus.waready, bus.wready}, 2'b00);
    chk("t4_b1_still", {bus.bvalid, bus.bdata}, {1'b1, 2'd2});
    chk("t4_reg3_unchanged", regs_o, model_flat());
    bus.bready = 1'b1;
    @(negedge clk);
    model[3] = 32'hC0DE_0003;
    chk("t4_b2_replaces", {bus.bvalid, bus.bdata}, {1'b1, 2'd0});
    chk("t4_b2_pulse", wr_pulse_o, 6'b001000);
    chk("t4_b2_regs", regs_o, model_flat());
    @(negedge clk);
    chk("t4_b2_clear", bus.bvalid, 0);

    // 5: back-to-back reads, then read backpressure
    @(negedge clk);
    bus.rready = 1'b1; bus.raddr = 5'h00; bus.arvalid = 1'b1;
    chk("t5_arready", bus.arready, 1);
    @(posedge clk); #1 bus.raddr = 5'h04;
    @(negedge clk);
    chk("t5_beat0", {bus.rvalid, bus.rdata}, {1'b1, model_read(5'h00)});
    @(posedge clk); #1 bus.raddr = 5'h08;
    @(negedge clk);
    chk("t5_beat1", {bus.rvalid, bus.rdata}, {1'b1, model_read(5'h04)});
    @(posedge clk); #1 bus.arvalid = 1'b0;
    @(negedge clk);
    chk("t5_beat2", {bus.rvalid, bus.rdata}, {1'b1, model_read(5'h08)});
    bus.rready = 1'b0; bus.raddr = 5'h00; bus.arvalid = 1'b1;
    #1 chk("t5_arready_stall", bus.arready, 0);
    repeat (3) begin
      @(negedge clk);
      chk("t5_hold", {bus.rvalid, bus.rdata, bus.arready}, {1'b1, model_read(5'h08), 1'b0});
    end
    bus.rready = 1'b1;
    #1 chk("t5_arready_resume", bus.arready, 1);
    @(posedge clk); #1 bus.arvalid = 1'b0;
    @(negedge clk);
    chk("t5_after_stall", {bus.rvalid, bus.rdata}, {1'b1, model_read(5'h00)});
    @(negedge clk);
    chk("t5_rvalid_clear", bus.rvalid, 0);

    // Randomized writes (random skew, unaligned addresses) interleaved with reads
    for (int i = 0; i < 24; i++) begin
      a = AW'($urandom_range(0, 31));
      d = $urandom;
      do_write(a, d, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      do_read(AW'($urandom_range(0, 31)));
    end

    // 6: reset while only the address slot is full
    send_aw(5'h00, 0);
    @(negedge clk);
    chk("t6_aw_held", bus.waready, 0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_waready", bus.waready, 0);
    chk("t6_rst_outputs", {bus.wready, bus.bvalid, bus.rvalid, bus.arready}, 4'b0000);
    chk("t6_rst_regs", regs_o, 0);
    chk("t6_rst_pulse", wr_pulse_o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NR; i++) model[i] = '0;
    @(negedge clk);
    chk("t6_waready", bus.waready, 1);
    send_w(32'h5555_AAAA, 0);
    repeat (3) @(negedge clk);
    chk("t6_no_stale_commit", bus.bvalid, 0);
    chk("t6_regs", regs_o, model_flat());
    do_read(5'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/axi_lite_reg_slave.md
Name: axi_lite_reg_slave

Overview:
Responder end of the `axi_lite_if` bus. It implements a bank of NUM_REGS word-wide control/status registers and sits behind any master that drives the interface's slave modport. Register contents are exposed flat to the datapath, with a one-cycle write pulse per register. The write address and write data channels are decoupled, so the two halves of a write may arrive in either order.

Parameters:
ADDR_WIDTH, 5, byte address width; must equal the bound interface's ADDR_WIDTH.
DATA_WIDTH, 32, register and bus data width.
NUM_REGS, 6, number of implemented registers, at word indices 0..NUM_REGS-1; must be <= 2**(ADDR_WIDTH-2).
RESET_VAL, 0, value loaded into every register on reset.

Ports:
clk  input  1  single clock; all logic on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
s_axi  interface  axi_lite_if.slave  bus port (waddr/wavalid/waready, wdata/wvalid/wready, bdata/bvalid/bready, raddr/arvalid/arready, rdata/rvalid/rready).
regs_o  output  NUM_REGS*DATA_WIDTH  register contents; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
wr_pulse_o  output  NUM_REGS  bit i high for exactly one cycle after register i is written.

Behaviour:
- Reset (async assert, sync release): all registers = RESET_VAL; waready, wready, bvalid, arready, rvalid, wr_pulse_o = 0; bdata, rdata = 0. Both holding slots are empty.
- A handshake on any channel occurs when valid && ready are high at a rising edge.
- Decode: word index = addr[ADDR_WIDTH-1:2]. addr[1:0] is ignored, so unaligned addresses alias to the enclosing word. An index >= NUM_REGS is out of range.
- Write address channel:
  - One-entry holding slot.
  - waready = !aw_held, registered; it is 1 in the first cycle after reset release.
  - On handshake, the address is captured and aw_held is set.
- Write data channel:
  - Independent one-entry slot.
  - wready = !w_held; on handshake, data is captured and w_held is set.
- Commit:
  - Occurs in the cycle where aw_held && w_held && (!bvalid || bready).
  - In range: register[idx] <= data, and wr_pulse_o[idx] = 1 in the next cycle.
  - Out of range: no register changes and no pulse.
  - Both slots clear. bvalid <= 1.
  - bdata <= 0 (OKAY) when in range, 2 (SLVERR) when out of range.
  - Write latency: one cycle from the later of the two handshakes to the commit decision; bvalid is high on the cycle after commit.
- Write response:
  - bvalid and bdata are held stable until bready.
  - A new commit may replace the response in the same cycle as a bready handshake; bvalid then stays high with the new bdata.
  - While bvalid && !bready, both slots may still fill, but no commit occurs.
- Read channel:
  - arready = !rvalid || rready, combinational on rready.
  - On handshake: rvalid <= 1 and rdata <= register[idx]; out of range returns 0.
  - Read latency is 1 cycle.
  - rvalid and rdata are held until rready. Back-to-back reads sustain one per cycle while rready = 1.
- Write and read of the same register in the same cycle: the read returns the pre-write value.
- Write and read channels are fully independent; there is no ordering between them.
- Reset asserted mid-transaction: slots are discarded, no partial write occurs, and all outputs return to reset values immediately.

Test Plan:
1. Write 0xA5A5_0001 to address 0x08 with waddr and wdata in the same cycle, bready = 1 -> bvalid one cycle after commit with bdata = 0; regs_o reg2 = 0xA5A5_0001; wr_pulse_o = 6'b000100 for exactly one cycle.
2. Present wdata = 0x1234 three cycles before waddr = 0x04 -> wready handshakes first and waready stays 1; commit occurs after the address handshake; reg1 = 0x1234.
3. Write to address 0x18 (index 6) with data 0xFFFF_FFFF -> bdata = 2, no wr_pulse_o, regs_o unchanged. Read 0x1C -> rdata = 0, rvalid = 1.
4. Hold bready = 0 for 5 cycles after write #1, then issue write #2 to 0x0C -> write #2 is accepted into the slots but reg3 is unchanged until bready rises; response #2 follows response #1.
5. Read 0x00, 0x04, 0x08 back-to-back with rready = 1 -> three rvalid beats on consecutive cycles. With rready = 0 -> rvalid/rdata held, and arready = 0 until rready returns.
6. Assert rst_n = 0 while aw_held = 1 and w_held = 0 -> all registers = RESET_VAL, waready = 0; after release, waready = 1 and a subsequent read of 0x00 returns RESET_VAL.
